// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if : handshake and register-file control bundle for control_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface control_unit_if;
    logic       start;
    logic       R1Le10;
    logic       RFSrcMuxSel;
    logic [2:0] r_addr_1;
    logic [2:0] r_addr_2;
    logic [2:0] wr_addr;
    logic       wr_en;
    logic       OutPortEn;
    logic       busy;
    logic       done;

    // Driver side: issues start, returns the datapath flag, observes control.
    modport master (
        output start,
        output R1Le10,
        input  RFSrcMuxSel,
        input  r_addr_1,
        input  r_addr_2,
        input  wr_addr,
        input  wr_en,
        input  OutPortEn,
        input  busy,
        input  done
    );

    // Controller side.
    modport slave (
        input  start,
        input  R1Le10,
        output RFSrcMuxSel,
        output r_addr_1,
        output r_addr_2,
        output wr_addr,
        output wr_en,
        output OutPortEn,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit : Moore FSM sequencing the sum 1..10 program on a 3-register datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_unit (
    input  wire logic     clk,
    input  wire logic     rst,
    control_unit_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT_I   = 4'd1,
        S_INIT_SUM = 4'd2,
        S_INIT_ONE = 4'd3,
        S_CMP      = 4'd4,
        S_ADD_SUM  = 4'd5,
        S_INC_I    = 4'd6,
        S_OUT      = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    localparam logic [2:0] c_REG_ZERO = 3'd0;
    localparam logic [2:0] c_REG_I    = 3'd1;
    localparam logic [2:0] c_REG_SUM  = 3'd2;
    localparam logic [2:0] c_REG_ONE  = 3'd3;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_src_sel;
    logic [2:0] w_ra1;
    logic [2:0] w_ra2;
    logic [2:0] w_wa;
    logic       w_we;
    logic       w_out_en;
    logic       w_busy;
    logic       w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        w_src_sel    = 1'b0;
        w_ra1        = c_REG_ZERO;
        w_ra2        = c_REG_ZERO;
        w_wa         = c_REG_ZERO;
        w_we         = 1'b0;
        w_out_en     = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy       = 1'b0;
                w_next_state = bus.start ? S_INIT_I : S_IDLE;
            end
            S_INIT_I: begin
                w_src_sel    = 1'b1;
                w_wa         = c_REG_I;
                w_we         = 1'b1;
                w_next_state = S_INIT_SUM;
            end
            S_INIT_SUM: begin
                // R0 + R0 through the adder clears the running sum.
                w_wa         = c_REG_SUM;
                w_we         = 1'b1;
                w_next_state = S_INIT_ONE;
            end
            S_INIT_ONE: begin
                w_src_sel    = 1'b1;
                w_wa         = c_REG_ONE;
                w_we         = 1'b1;
                w_next_state = S_CMP;
            end
            S_CMP: begin
                w_ra1        = c_REG_I;
                w_next_state = bus.R1Le10 ? S_ADD_SUM : S_DONE;
            end
            S_ADD_SUM: begin
                w_ra1        = c_REG_SUM;
                w_ra2        = c_REG_I;
                w_wa         = c_REG_SUM;
                w_we         = 1'b1;
                w_next_state = S_INC_I;
            end
            S_INC_I: begin
                w_ra1        = c_REG_I;
                w_ra2        = c_REG_ONE;
                w_wa         = c_REG_I;
                w_we         = 1'b1;
                w_next_state = S_OUT;
            end
            S_OUT: begin
                w_ra1        = c_REG_SUM;
                w_out_en     = 1'b1;
                w_next_state = S_CMP;
            end
            S_DONE: begin
                w_ra1        = c_REG_SUM;
                w_out_en     = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE with all outputs quiet.
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.RFSrcMuxSel = w_src_sel;
    assign bus.r_addr_1    = w_ra1;
    assign bus.r_addr_2    = w_ra2;
    assign bus.wr_addr     = w_wa;
    assign bus.wr_en       = w_we;
    assign bus.OutPortEn   = w_out_en;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit : directed self-checking bench with a behavioural datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic open_loop = 1'b0;
    int   checks = 0;
    int   errors = 0;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: 8x8 register file, adder, write mux, output port.
    logic [7:0] rf [0:7];
    logic [7:0] out_port = 8'd0;
    logic [7:0] rdata1;
    logic [7:0] rdata2;
    logic [7:0] wdata;

    assign rdata1     = (bus.r_addr_1 == 3'd0) ? 8'd0 : rf[bus.r_addr_1];
    assign rdata2     = (bus.r_addr_2 == 3'd0) ? 8'd0 : rf[bus.r_addr_2];
    assign wdata      = bus.RFSrcMuxSel ? 8'd1 : (rdata1 + rdata2);
    assign bus.R1Le10 = open_loop ? 1'b0 : (rdata1 <= 8'd10);

    always_ff @(posedge clk) begin
        if (bus.wr_en && bus.wr_addr != 3'd0) rf[bus.wr_addr] <= wdata;
        if (bus.OutPortEn) out_port <= rdata1;
    end

    // {RFSrcMuxSel, r_addr_1, r_addr_2, wr_addr, wr_en, OutPortEn, busy, done}
    logic [13:0] pack;
    assign pack = {bus.RFSrcMuxSel, bus.r_addr_1, bus.r_addr_2, bus.wr_addr,
                   bus.wr_en, bus.OutPortEn, bus.busy, bus.done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_closed(input int pulse_at, input string tag);
        int  nb;
        int  nd;
        int  no;
        bit  seq_ok;
        logic [7:0] exp_v;
        nb = 0; nd = 0; no = 0; seq_ok = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.busy) nb++;
            if (bus.done) nd++;
            if (bus.OutPortEn) begin
                no++;
                exp_v = (no <= 10) ? 8'(no * (no + 1) / 2) : 8'd55;
                if (rdata1 !== exp_v) seq_ok = 1'b0;
            end
            bus.start = (c == pulse_at);
            tick();
        end
        bus.start = 1'b0;
        check({tag, "_busy_cycles"}, nb, 45);
        check({tag, "_done_pulses"}, nd, 1);
        check({tag, "_out_loads"}, no, 11);
        check({tag, "_out_sequence"}, {31'd0, seq_ok}, 1);
        check({tag, "_out_port"}, {24'd0, out_port}, 55);
        check({tag, "_idle_after"}, {18'd0, pack}, 0);
    endtask

    initial begin
        logic [13:0] exp_open [0:5];
        int  adds;
        bit  found;
        int  t1;
        int  t2;
        int  nb;
        int  ni;
        int  cyc;

        for (int i = 0; i < 8; i++) rf[i] = 8'd0;
        bus.start = 1'b0;

        // Reset held two cycles, then quiet IDLE with start low.
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", {18'd0, pack}, 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_quiet", {18'd0, pack}, 0);
        end

        // Closed-loop run, single start pulse.
        run_closed(0, "run1");

        // Open loop with the flag forced low: short program.
        exp_open[0] = {1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_open[1] = {1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_open[2] = {1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_open[3] = {1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_open[4] = {1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_open[5] = 14'd0;
        open_loop = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("open_loop_cycle%0d", c + 1), {18'd0, pack}, {18'd0, exp_open[c]});
            tick();
        end
        open_loop = 1'b0;

        // Start pulsed mid-run has no effect.
        run_closed(20, "restart_ignored");

        // Reset during the fourth ADD_SUM aborts the run.
        adds = 0;
        found = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (bus.wr_en && bus.wr_addr == 3'd2 && bus.r_addr_1 == 3'd2) adds++;
            if (adds == 4) found = 1'b1;
            else tick();
        end
        check("abort_found_add4", {31'd0, found}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_idle", {18'd0, pack}, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("abort_no_writes", {30'd0, bus.wr_en, bus.busy}, 0);
        end
        run_closed(0, "after_abort");

        // Start held high: back-to-back runs.
        t1 = -1; t2 = -1; nb = 0; ni = 0; cyc = 0;
        bus.start = 1'b1;
        while (t2 < 0 && cyc < 200) begin
            tick();
            cyc++;
            if (t1 >= 0) begin
                if (bus.busy) nb++;
                else ni++;
            end
            if (bus.done) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        bus.start = 1'b0;
        check("held_second_done_seen", {31'd0, (t2 >= 0)}, 1);
        check("held_done_period", t2 - t1, 46);
        check("held_busy_cycles", nb, 45);
        check("held_idle_cycles", ni, 1);
        check("held_out_port", {24'd0, out_port}, 55);
        tick();
        check("held_idle_after", {18'd0, pack}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; register indices, loop bound and state encoding are fixed.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates occur on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is the reset; it is synchronous and active-high.
REQ-004 The port start SHALL be an input, 1 bit wide, and requests one program run; it is sampled only in IDLE.
REQ-005 The port R1Le10 SHALL be an input, 1 bit wide, and is the datapath flag (r_data_1 <= 10).
REQ-006 The port RFSrcMuxSel SHALL be an output, 1 bit wide: 0 selects the adder result, 1 selects constant 1 as the register-file write data.
REQ-007 The ports r_addr_1 and r_addr_2 SHALL be outputs, 3 bits each, and are the register-file read addresses (address 0 reads 0).
REQ-008 The port wr_addr SHALL be an output, 3 bits wide, and is the register-file write address.
REQ-009 The port wr_en SHALL be an output, 1 bit wide, and is the register-file write enable.
REQ-010 The port OutPortEn SHALL be an output, 1 bit wide, and loads r_data_1 into the datapath output register.
REQ-011 The port busy SHALL be an output, 1 bit wide, and is high in every state except IDLE.
REQ-012 The port done SHALL be an output, 1 bit wide, and pulses high for one cycle when the run completes.

Function
REQ-013 The block SHALL be a Moore FSM; all outputs are decoded from the current state only.
REQ-014 Register roles SHALL be fixed: R1 = loop index i, R2 = running sum, R3 = constant 1.
REQ-015 In every state, outputs not listed for that state SHALL be 0.
REQ-016 IDLE SHALL go to INIT_I when start=1 and otherwise stay in IDLE.
REQ-017 INIT_I SHALL drive RFSrcMuxSel=1, wr_addr=1, wr_en=1 (R1<=1), then go to INIT_SUM.
REQ-018 INIT_SUM SHALL drive RFSrcMuxSel=0, r_addr_1=0, r_addr_2=0, wr_addr=2, wr_en=1 (R2<=0), then go to INIT_ONE.
REQ-019 INIT_ONE SHALL drive RFSrcMuxSel=1, wr_addr=3, wr_en=1 (R3<=1), then go to CMP.
REQ-020 CMP SHALL drive r_addr_1=1, then go to ADD_SUM if R1Le10=1 and to DONE otherwise.
REQ-021 ADD_SUM SHALL drive r_addr_1=2, r_addr_2=1, RFSrcMuxSel=0, wr_addr=2, wr_en=1 (R2<=R2+R1), then go to INC_I.
REQ-022 INC_I SHALL drive r_addr_1=1, r_addr_2=3, RFSrcMuxSel=0, wr_addr=1, wr_en=1 (R1<=R1+1), then go to OUT.
REQ-023 OUT SHALL drive r_addr_1=2 and OutPortEn=1 (publish the running sum), then go to CMP.
REQ-024 DONE SHALL drive r_addr_1=2, OutPortEn=1 and done=1, then go to IDLE.
REQ-025 A run SHALL take exactly 45 cycles from the first non-IDLE state to the last: 3 init, 10 loops of 4, final CMP, DONE.
REQ-026 start SHALL be ignored in every non-IDLE state; runs are never queued or restarted.
REQ-027 start held high through DONE SHALL start a new run, giving IDLE for one cycle and then INIT_I.
REQ-028 If the state register holds any unused encoding, the block SHALL go to IDLE on the next edge.
REQ-029 The block SHALL perform no arithmetic; 8-bit wrap-around is handled by the datapath and is not reachable for this program (maximum sum 55).

Reset
REQ-030 When rst=1 at a rising edge, the state SHALL become IDLE; rst takes priority over start and all transitions.
REQ-031 In reset/IDLE, every output SHALL be 0, including wr_en, OutPortEn, busy and done.
REQ-032 Reset asserted mid-run SHALL abort the run with no further writes; register-file contents are left as they are.

Verification
REQ-033 Reset held 2 cycles, then released with start=0 -> state stays IDLE and all outputs stay 0 for 10 cycles.
REQ-034 Closed loop with the datapath, 1-cycle start pulse -> OutPort sequence 1,3,6,...,55 (one update per OUT); done pulses once; busy is high for exactly 45 cycles.
REQ-035 Open loop, R1Le10 forced 0 -> sequence INIT_I, INIT_SUM, INIT_ONE, CMP, DONE; done is high on cycle 5; wr_en is high on cycles 1-3 only.
REQ-036 start pulsed again on cycle 20 of a run -> no effect; the run still ends with OutPort=55 and one done pulse.
REQ-037 rst asserted during ADD_SUM of iteration 4 -> IDLE on the next edge, wr_en=0 from then on; a new start gives OutPort=55 again.
REQ-038 start held high continuously -> back-to-back runs, each 45 busy cycles followed by 1 IDLE cycle, and done pulses every 46 cycles.
